skullfet_tester: RTL and testbench

On-chip functional tester for the hand-drawn SkullFET standard cells (inverter and NAND) in the user project area. It drives all 8 input combinations onto the cells and waits a programmable settle time per vector. It samples the cells' outputs through synchronizers, compares them against expected logic and reports pass/fail plus an error count. It sits between the Wishbone-clocked control logic and the cell instances, replacing direct pad drive of the cell inputs.

---
 rtl/skullfet_pkg.sv | 23 ++
 rtl/skullfet_sync2.sv | 21 ++
 rtl/skullfet_tester.sv | 162 ++++++++++++++++
 tb/tb_skullfet_tester.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/skullfet_pkg.sv
// Shared types, vector constants and expected-value functions for the SkullFET cell tester.
package skullfet_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int VEC_W = 3;
  localparam logic [VEC_W-1:0] VEC_LAST = 3'd7;

  // vec is ordered {inv_a, nand_a, nand_b}
  function automatic logic exp_inv(input logic [VEC_W-1:0] vec);
    return ~vec[2];
  endfunction

  function automatic logic exp_nand(input logic [VEC_W-1:0] vec);
    return ~(vec[1] & vec[0]);
  endfunction

endpackage

// File: rtl/skullfet_sync2.sv
// Two-flop synchronizer for one asynchronous cell output; resets to 0.
module skullfet_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/skullfet_tester.sv
// Functional tester for the SkullFET inverter and NAND cells: steps all 8 input vectors,
// checks synchronized outputs and counts mismatches. Optional first-failure capture: SKULLFET_TESTER_CAPTURE_EN.
module skullfet_tester
  import skullfet_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int ERR_W         = 5
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  output logic             inv_a_o,
  output logic             nand_a_o,
  output logic             nand_b_o,
  input  logic             inv_y_i,
  input  logic             nand_y_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [2:0]       fail_vec_o,
  output logic             fail_valid_o,
  output logic [1:0]       dbg_state_o
);

  // Run handshake: a start_i seen in IDLE or DONE (without abort_i) launches a run; busy_o
  // stays high until done_o rises, and done_o/pass_o/err_cnt_o then hold until start or abort.

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_t             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [VEC_W-1:0]   drive_q, drive_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [ERR_W:0]     err_sum;
  logic               inv_s, nand_s;
  logic               inv_mis, nand_mis;
  logic               start_run;

  skullfet_sync2 u_sync_inv (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .d   (inv_y_i),
    .q   (inv_s)
  );

  skullfet_sync2 u_sync_nand (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .d   (nand_y_i),
    .q   (nand_s)
  );

  assign inv_mis  = (state_q == ST_CHECK) && (inv_s  != exp_inv(vec_q));
  assign nand_mis = (state_q == ST_CHECK) && (nand_s != exp_nand(vec_q));
  assign err_sum  = {1'b0, err_q} + {{ERR_W{1'b0}}, inv_mis} + {{ERR_W{1'b0}}, nand_mis};

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    start_run = 1'b0;
    if (abort_i) begin
      state_d = ST_IDLE;
      vec_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_d   = ST_SETTLE;
            vec_d     = '0;
            cnt_d     = '0;
            err_d     = '0;
            start_run = 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_CHECK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_CHECK: begin
          err_d = err_sum[ERR_W] ? ERR_MAX : err_sum[ERR_W-1:0];
          if (vec_q == VEC_LAST) begin
            state_d = ST_DONE;
            vec_d   = '0;
          end else begin
            state_d = ST_SETTLE;
            vec_d   = vec_q + VEC_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Cell inputs come from a register loaded from next-state values, so they only move on SETTLE entry.
  always_comb begin
    drive_d = '0;
    if (state_d == ST_SETTLE || state_d == ST_CHECK)
      drive_d = vec_d;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      drive_q <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      drive_q <= drive_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

`ifdef SKULLFET_TESTER_CAPTURE_EN
  logic [VEC_W-1:0] fail_vec_q;
  logic             fail_valid_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      fail_vec_q   <= '0;
      fail_valid_q <= 1'b0;
    end else if (start_run) begin
      fail_vec_q   <= '0;
      fail_valid_q <= 1'b0;
    end else if (!abort_i && !fail_valid_q && (inv_mis || nand_mis)) begin
      fail_vec_q   <= vec_q;
      fail_valid_q <= 1'b1;
    end
  end

  assign fail_vec_o   = fail_vec_q;
  assign fail_valid_o = fail_valid_q;
`else
  assign fail_vec_o   = 3'b000;
  assign fail_valid_o = 1'b0;
`endif

  assign inv_a_o     = drive_q[2];
  assign nand_a_o    = drive_q[1];
  assign nand_b_o    = drive_q[0];
  assign busy_o      = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
  assign done_o      = (state_q == ST_DONE);
  assign pass_o      = done_o && (err_q == '0);
  assign err_cnt_o   = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_skullfet_tester.sv
// Directed bench for skullfet_tester: ideal and stuck-at cell models, abort, reset and saturation.
module tb_skullfet_tester;

`ifdef SKULLFET_TESTER_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0;
  logic inv_a, nand_a, nand_b, inv_y, nand_y;
  logic busy, done, pass_r, fail_valid;
  logic [4:0] err_cnt;
  logic [2:0] fail_vec;
  logic [1:0] dbg_state;
  logic inv_stuck1 = 1'b0, nand_stuck0 = 1'b0;

  logic start2 = 1'b0, abort2 = 1'b0, zero_y = 1'b0;
  logic inv_a2, nand_a2, nand_b2, busy2, done2, pass2, fail_valid2;
  logic [1:0] err_cnt2, dbg_state2;
  logic [2:0] fail_vec2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign inv_y  = inv_stuck1  ? 1'b1 : ~inv_a;
  assign nand_y = nand_stuck0 ? 1'b0 : ~(nand_a & nand_b);

  skullfet_tester #(.SETTLE_CYCLES(16), .ERR_W(5)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .abort_i(abort),
    .inv_a_o(inv_a), .nand_a_o(nand_a), .nand_b_o(nand_b),
    .inv_y_i(inv_y), .nand_y_i(nand_y),
    .busy_o(busy), .done_o(done), .pass_o(pass_r), .err_cnt_o(err_cnt),
    .fail_vec_o(fail_vec), .fail_valid_o(fail_valid), .dbg_state_o(dbg_state)
  );

  skullfet_tester #(.SETTLE_CYCLES(3), .ERR_W(2)) dut_sat (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start2), .abort_i(abort2),
    .inv_a_o(inv_a2), .nand_a_o(nand_a2), .nand_b_o(nand_b2),
    .inv_y_i(zero_y), .nand_y_i(zero_y),
    .busy_o(busy2), .done_o(done2), .pass_o(pass2), .err_cnt_o(err_cnt2),
    .fail_vec_o(fail_vec2), .fail_valid_o(fail_valid2), .dbg_state_o(dbg_state2)
  );

  task automatic test_reset();
    n_vec++;
    if ({busy, done, pass_r, inv_a, nand_a, nand_b, err_cnt, fail_valid, fail_vec, dbg_state} !== 17'd0) begin
      n_err++; $display("FAIL reset_init: outputs=%b expected all 0",
        {busy, done, pass_r, inv_a, nand_a, nand_b, err_cnt, fail_valid, fail_vec, dbg_state});
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    n_vec++;
    if ({busy, inv_a, nand_a, nand_b} !== 4'b1001) begin
      n_err++; $display("FAIL reset_prerun: busy/vec=%b expected 1001", {busy, inv_a, nand_a, nand_b});
    end
    #3 rst = 1'b1;
    #1;
    n_vec++;
    if ({busy, done, pass_r, inv_a, nand_a, nand_b, err_cnt, dbg_state} !== 13'd0) begin
      n_err++; $display("FAIL reset_async: outputs=%b expected all 0",
        {busy, done, pass_r, inv_a, nand_a, nand_b, err_cnt, dbg_state});
    end
    @(negedge clk); rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_vec++;
    if ({dbg_state, busy, done, inv_a, nand_a, nand_b} !== 7'd0) begin
      n_err++; $display("FAIL reset_idle: state/busy/done/vec=%b expected 0",
        {dbg_state, busy, done, inv_a, nand_a, nand_b});
    end
  endtask

  // Full timed run on the main DUT; optional start pulses while busy must not disturb it.
  task automatic run_full(input string name, input logic [4:0] exp_err,
                          input logic [2:0] exp_fvec, input logic exp_fvalid, input bit pulse);
    logic [2:0] exp_vec;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n_vec++;
    if ({busy, done, inv_a, nand_a, nand_b} !== 5'b10000) begin
      n_err++; $display("FAIL %s_t0: busy/done/vec=%b expected 10000", name, {busy, done, inv_a, nand_a, nand_b});
    end
    for (int n = 1; n <= 136; n++) begin
      @(posedge clk); #1;
      start = pulse && (n == 20 || n == 100);
      if (n % 17 == 0 && n < 136) begin
        exp_vec = 3'(n / 17);
        n_vec++;
        if ({inv_a, nand_a, nand_b} !== exp_vec) begin
          n_err++; $display("FAIL %s_vec@%0d: got %b expected %b", name, n, {inv_a, nand_a, nand_b}, exp_vec);
        end
      end
      if (n == 135) begin
        n_vec++;
        if ({busy, done} !== 2'b10) begin
          n_err++; $display("FAIL %s_early_done: busy/done=%b expected 10", name, {busy, done});
        end
      end
    end
    start = 1'b0;
    n_vec++;
    if ({busy, done, pass_r, inv_a, nand_a, nand_b} !== {2'b01, (exp_err == 5'd0), 3'b000}) begin
      n_err++; $display("FAIL %s_done: busy/done/pass/vec=%b expected %b", name,
        {busy, done, pass_r, inv_a, nand_a, nand_b}, {2'b01, (exp_err == 5'd0), 3'b000});
    end
    n_vec++;
    if (err_cnt !== exp_err) begin
      n_err++; $display("FAIL %s_err_cnt: got %0d expected %0d", name, err_cnt, exp_err);
    end
    n_vec++;
    if ({fail_valid, fail_vec} !== {exp_fvalid, exp_fvec}) begin
      n_err++; $display("FAIL %s_capture: got %b expected %b", name, {fail_valid, fail_vec}, {exp_fvalid, exp_fvec});
    end
    repeat (3) begin @(posedge clk); #1; end
    n_vec++;
    if ({done, pass_r, err_cnt} !== {1'b1, (exp_err == 5'd0), exp_err}) begin
      n_err++; $display("FAIL %s_hold: done/pass/err=%b expected %b", name, {done, pass_r, err_cnt},
        {1'b1, (exp_err == 5'd0), exp_err});
    end
  endtask

  task automatic test_ideal();
    run_full("ideal", 5'd0, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic test_nand_stuck0();
    nand_stuck0 = 1'b1;
    run_full("nand_stuck0", 5'd6, CAP ? 3'b000 : 3'b000, CAP, 1'b0);
    nand_stuck0 = 1'b0;
  endtask

  task automatic test_inv_stuck1();
    inv_stuck1 = 1'b1;
    run_full("inv_stuck1", 5'd4, CAP ? 3'b100 : 3'b000, CAP, 1'b0);
    inv_stuck1 = 1'b0;
  endtask

  task automatic test_abort();
    nand_stuck0 = 1'b1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (55) begin @(posedge clk); #1; end
    n_vec++;
    if ({busy, inv_a, nand_a, nand_b, err_cnt} !== {4'b1011, 5'd3}) begin
      n_err++; $display("FAIL abort_pre: busy/vec/err=%b expected %b", {busy, inv_a, nand_a, nand_b, err_cnt}, {4'b1011, 5'd3});
    end
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    n_vec++;
    if ({dbg_state, busy, done, pass_r, inv_a, nand_a, nand_b, err_cnt} !== {2'b00, 6'b000000, 5'd3}) begin
      n_err++; $display("FAIL abort_idle: state/busy/done/pass/vec/err=%b expected %b",
        {dbg_state, busy, done, pass_r, inv_a, nand_a, nand_b, err_cnt}, {2'b00, 6'b000000, 5'd3});
    end
    n_vec++;
    if ({fail_valid, fail_vec} !== {CAP, 3'b000}) begin
      n_err++; $display("FAIL abort_capture: got %b expected %b", {fail_valid, fail_vec}, {CAP, 3'b000});
    end
    nand_stuck0 = 1'b0;
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    n_vec++;
    if ({dbg_state, busy, done, inv_a, nand_a, nand_b, err_cnt} !== {7'd0, 5'd3}) begin
      n_err++; $display("FAIL start_abort_idle: state/busy/done/vec/err=%b expected %b",
        {dbg_state, busy, done, inv_a, nand_a, nand_b, err_cnt}, {7'd0, 5'd3});
    end
  endtask

  task automatic test_back_to_back();
    run_full("restart_busy_start", 5'd0, 3'b000, 1'b0, 1'b1);
    run_full("back_to_back", 5'd0, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic test_saturate();
    @(negedge clk); start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    for (int n = 1; n <= 32; n++) begin
      @(posedge clk); #1;
      if (n == 4) begin
        n_vec++;
        if (err_cnt2 !== 2'd2) begin
          n_err++; $display("FAIL sat_first_check: got %0d expected 2", err_cnt2);
        end
      end
      if (n == 31) begin
        n_vec++;
        if ({busy2, done2} !== 2'b10) begin
          n_err++; $display("FAIL sat_early_done: busy/done=%b expected 10", {busy2, done2});
        end
      end
    end
    n_vec++;
    if ({busy2, done2, pass2, err_cnt2} !== 5'b01011) begin
      n_err++; $display("FAIL sat_done: busy/done/pass/err=%b expected 01011", {busy2, done2, pass2, err_cnt2});
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_ideal();
    test_nand_stuck0();
    test_inv_stuck1();
    test_abort();
    test_back_to_back();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
